wgt_loader: RTL and testbench

Weight fetch controller directly upstream of the three-tap weight shift buffer in the convolution accelerator. It reads signed 8-bit weights from a synchronous weight SRAM, three per kernel row, and shifts them into the buffer through `wgt_input`/`wgt_read`. After each row it raises `row_ready` and holds the buffer stable until the PE acknowledges. It then fetches the next row, or signals `done` once `num_rows` rows have been delivered.

---
 rtl/wgt_loader.sv | 181 ++++++++++++++++++
 tb/tb_wgt_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_loader.sv
// ----------------------------------------------------------------------------
// wgt_loader
// Weight fetch controller feeding the three-tap weight shift buffer of the
// convolution accelerator. For each kernel row it reads three signed 8-bit
// weights from a synchronous SRAM, shifts them into the buffer, presents the
// row with row_ready and waits for the PE to acknowledge before fetching the
// next one. A one-cycle done pulse closes the sequence.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 begin a load sequence (sampled in IDLE only)
//   base_addr, num_rows   first weight address / row count, latched on start
//   mem_rd_en, mem_addr   SRAM read strobe and address
//   mem_rd_data           SRAM read data, valid one cycle after mem_rd_en
//   wgt_input, wgt_read   weight and shift strobe to the buffer (registered)
//   row_ready             buffer holds a complete row (level)
//   pe_ack                PE has consumed the presented row
//   row_idx               index of the row being loaded or presented
//   busy                  controller not in IDLE
//   done                  one-cycle pulse at the end of a sequence
// ----------------------------------------------------------------------------
module wgt_loader #(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ROW_W-1:0]  num_rows,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        wgt_input,
    output logic              wgt_read,
    output logic              row_ready,
    input  logic              pe_ack,
    output logic [ROW_W-1:0]  row_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        READY = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        cnt_r, cnt_s;          // cycle counter within FETCH / DRAIN
    logic [ADDR_W-1:0] addr_r, addr_s;        // next SRAM address to read
    logic [ROW_W-1:0]  row_lim_r, row_lim_s;
    logic [ROW_W-1:0]  row_idx_r, row_idx_s;

    logic              rd_en_r;
    logic              row_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_dly_r;              // read strobe aligned with mem_rd_data
    logic              wgt_read_r;
    logic [7:0]        wgt_input_r;

    // Next-state and datapath update decode for the load sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = addr_r;
        row_lim_s = row_lim_r;
        row_idx_s = row_idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_s    = base_addr;
                    row_lim_s = num_rows;
                    row_idx_s = '0;
                    cnt_s     = 2'd0;
                    if (num_rows == '0) begin
                        state_s = FIN;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // Address wraps naturally at 2^ADDR_W.
                addr_s = addr_r + ADDR_W'(1);
                if (cnt_r == 2'd2) begin
                    cnt_s   = 2'd0;
                    state_s = DRAIN;
                end else begin
                    cnt_s = cnt_r + 2'd1;
                end
            end
            DRAIN: begin
                if (cnt_r == 2'd1) begin
                    cnt_s   = 2'd0;
                    state_s = READY;
                end else begin
                    cnt_s = cnt_r + 2'd1;
                end
            end
            READY: begin
                if (pe_ack) begin
                    if (row_idx_r + ROW_W'(1) == row_lim_r) begin
                        state_s = FIN;
                    end else begin
                        row_idx_s = row_idx_r + ROW_W'(1);
                        cnt_s     = 2'd0;
                        state_s   = FETCH;
                    end
                end else begin
                    state_s = READY;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and state-decoded output flops; outputs track the
    // state being entered so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            addr_r      <= '0;
            row_lim_r   <= '0;
            row_idx_r   <= '0;
            rd_en_r     <= 1'b0;
            row_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            addr_r      <= addr_s;
            row_lim_r   <= row_lim_s;
            row_idx_r   <= row_idx_s;
            rd_en_r     <= (state_s == FETCH);
            row_ready_r <= (state_s == READY);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == FIN);
        end
    end

    // Read-to-shift pipeline: delay the strobe to meet the SRAM data, then
    // register data and strobe towards the buffer. wgt_input holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dly_r    <= 1'b0;
            wgt_read_r  <= 1'b0;
            wgt_input_r <= 8'd0;
        end else begin
            rd_dly_r   <= rd_en_r;
            wgt_read_r <= rd_dly_r;
            if (rd_dly_r) begin
                wgt_input_r <= mem_rd_data;
            end else begin
                wgt_input_r <= wgt_input_r;
            end
        end
    end

    assign mem_rd_en = rd_en_r;
    assign mem_addr  = addr_r;
    assign wgt_input = wgt_input_r;
    assign wgt_read  = wgt_read_r;
    assign row_ready = row_ready_r;
    assign row_idx   = row_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_wgt_loader.sv
// ----------------------------------------------------------------------------
// tb_wgt_loader
// Self-checking bench for wgt_loader: an SRAM model, a downstream three-tap
// buffer model and a scoreboard of expected addresses/weights per sequence.
// ----------------------------------------------------------------------------
module tb_wgt_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] base_addr = 10'd0;
    logic [7:0] num_rows = 8'd0;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic [7:0] wgt_input;
    logic       wgt_read;
    logic       row_ready;
    logic       pe_ack = 1'b0;
    logic [7:0] row_idx;
    logic       busy;
    logic       done;

    wgt_loader #(.ADDR_W(10), .ROW_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .wgt_input(wgt_input), .wgt_read(wgt_read),
        .row_ready(row_ready), .pe_ack(pe_ack), .row_idx(row_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous weight SRAM: data one cycle after the read strobe.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    typedef struct {
        int base;
        int nrows;
        int d;        // PE hold cycles before ack; 0 means pe_ack tied high
        bit noise;    // pulse start/pe_ack during FETCH and DRAIN
        int exp_done; // cycle of done relative to the start edge
    } vec_t;

    vec_t vt [6];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_addr_q [$];
    int exp_wgt_q [$];
    int rd_cnt, wr_cnt, rise_cnt, done_cnt, done_cyc, first_rd, first_wr;
    int cur_base, cur_d;
    int tap0, tap1, tap2;
    bit rr_prev;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    function automatic int mem_at(input int a);
        return int'($signed(mem[a % 1024]));
    endfunction

    // Per-cycle monitor: scoreboard pops, buffer model, row/done tracking.
    task automatic sample();
        if (rst_n) begin
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("mem_addr", int'(mem_addr), exp_addr_q.pop_front());
                chk("no_prefetch", int'(row_ready), 0);
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (wgt_read) begin
                if (exp_wgt_q.size() == 0) chk("unexpected_shift", 1, 0);
                else chk("wgt_input", int'($signed(wgt_input)), exp_wgt_q.pop_front());
                tap2 = tap1;
                tap1 = tap0;
                tap0 = int'($signed(wgt_input));
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
            end
            if (row_ready) begin
                chk("hold_no_shift", int'(wgt_read), 0);
            end
            if (row_ready && !rr_prev) begin
                chk("row_idx", int'(row_idx), rise_cnt);
                chk("row_ready_cycle", cyc - t0, 6 + rise_cnt * (6 + cur_d));
                chk("tap2", tap2, mem_at(cur_base + 3 * rise_cnt));
                chk("tap1", tap1, mem_at(cur_base + 3 * rise_cnt + 1));
                chk("tap0", tap0, mem_at(cur_base + 3 * rise_cnt + 2));
                rise_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", int'(busy), 1);
            end
            rr_prev = row_ready;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        sample();
    endtask

    task automatic clear_sb(input int base, input int nrows, input int d);
        exp_addr_q.delete();
        exp_wgt_q.delete();
        rd_cnt = 0; wr_cnt = 0; rise_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_rd = -1; first_wr = -1;
        rr_prev = 1'b0;
        cur_base = base;
        cur_d = d;
        for (int r = 0; r < nrows; r++) begin
            for (int i = 0; i < 3; i++) begin
                exp_addr_q.push_back((base + 3 * r + i) % 1024);
                exp_wgt_q.push_back(mem_at(base + 3 * r + i));
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int wait_cnt;
        wait_cnt = 0;
        clear_sb(v.base, v.nrows, v.d);
        step();
        start = 1'b1;
        base_addr = 10'(v.base);
        num_rows = 8'(v.nrows);
        t0 = cyc;
        if (v.d == 0) pe_ack = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0 && cyc >= done_cyc + 1) break;
            if (v.noise && cyc == t0 + 2) begin
                start = 1'b1;
                base_addr = 10'd300;
                num_rows = 8'd5;
                pe_ack = 1'b1;
            end else if (v.noise && cyc == t0 + 4) begin
                start = 1'b0;
                pe_ack = 1'b1;
            end else begin
                start = 1'b0;
                if (v.d == 0) begin
                    pe_ack = 1'b1;
                end else begin
                    pe_ack = row_ready && (wait_cnt == v.d);
                    wait_cnt = row_ready ? wait_cnt + 1 : 0;
                end
            end
            step();
        end
        pe_ack = 1'b0;
        start = 1'b0;
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc - t0, v.exp_done);
        chk("busy_after_done", int'(busy), 0);
        chk("read_count", rd_cnt, 3 * v.nrows);
        chk("shift_count", wr_cnt, 3 * v.nrows);
        chk("row_count", rise_cnt, v.nrows);
        chk("addr_q_left", exp_addr_q.size(), 0);
        if (v.nrows > 0) begin
            chk("first_read_cycle", first_rd - t0, 1);
            chk("first_shift_cycle", first_wr - t0, 3);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        mem[16] = 8'd5;
        mem[17] = 8'hFD;   // -3
        mem[18] = 8'd7;
        tap0 = 0; tap1 = 0; tap2 = 0;

        vt[0] = '{16,   1, 2,  1'b0, 9};   // single row
        vt[1] = '{0,    3, 0,  1'b0, 19};  // three rows, pe_ack tied high
        vt[2] = '{1022, 1, 1,  1'b0, 8};   // address wrap
        vt[3] = '{100,  0, 1,  1'b0, 1};   // zero rows
        vt[4] = '{200,  2, 3,  1'b1, 19};  // ignored start / early pe_ack
        vt[5] = '{40,   1, 50, 1'b0, 57};  // long PE hold

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_wgt_input", int'(wgt_input), 0);
        chk("rst_wgt_read", int'(wgt_read), 0);
        chk("rst_row_ready", int'(row_ready), 0);
        chk("rst_row_idx", int'(row_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) run_vec(vt[v]);

        // Reset during DRAIN of row 1 of a two-row sequence.
        clear_sb(60, 2, 0);
        step();
        start = 1'b1;
        base_addr = 10'd60;
        num_rows = 8'd2;
        pe_ack = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        while (cyc < t0 + 10) step();
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_rd_en", int'(mem_rd_en), 0);
        chk("async_mem_addr", int'(mem_addr), 0);
        chk("async_wgt_input", int'(wgt_input), 0);
        chk("async_wgt_read", int'(wgt_read), 0);
        chk("async_row_ready", int'(row_ready), 0);
        chk("async_row_idx", int'(row_idx), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        pe_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc++;
            chk("no_done_in_reset", int'(done), 0);
        end
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", int'(busy), 0);
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
